div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl.sv | 171 +++++++++++++++++
 tb/tb_div_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl
// Description : Control unit for a 10-bit / 5-bit restoring divider.
//               Issues load/shift/subtract strobes to an external datapath.
//               The datapath holds the W register ({remainder, quotient}),
//               the divisor register and an iteration counter.
//               Each division runs five SHIFT/SUB pairs.
//               The controller flags divide-by-zero and quotient overflow
//               before it starts iterating.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               start               - division request (honoured in IDLE)
//               ov, divbyzero       - operand checks from the datapath
//               is_neg, co          - subtract sign, counter terminal count
//               muxsel..cnt_en      - datapath control strobes
//               busy, done          - status (done is a one-cycle pulse)
//               err_dz, err_ov      - error flags of the last operation
// Revision    : 1.0 - initial release
// ============================================================================
module div_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ov,
    input  logic divbyzero,
    input  logic is_neg,
    input  logic co,
    output logic muxsel,
    output logic ldw,
    output logic shw,
    output logic clrw,
    output logic ser_in,
    output logic setq0_to1,
    output logic add_sub_sel,
    output logic ldd,
    output logic clrd,
    output logic clrcnt,
    output logic cnt_en,
    output logic busy,
    output logic done,
    output logic err_dz,
    output logic err_ov
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_SUB   = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t state_q, state_d;
    logic   err_dz_q, err_dz_d;
    logic   err_ov_q, err_ov_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            err_dz_q <= 1'b0;
            err_ov_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            err_dz_q <= err_dz_d;
            err_ov_q <= err_ov_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        err_dz_d    = err_dz_q;
        err_ov_d    = err_ov_q;
        muxsel      = 1'b0;
        ldw         = 1'b0;
        shw         = 1'b0;
        clrw        = 1'b0;
        ser_in      = 1'b0;
        setq0_to1   = 1'b0;
        add_sub_sel = 1'b0;
        ldd         = 1'b0;
        clrd        = 1'b0;
        clrcnt      = 1'b0;
        cnt_en      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        err_dz      = err_dz_q;
        err_ov      = err_ov_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    // Flags clear on entry so they already read 0 during LOAD.
                    err_dz_d = 1'b0;
                    err_ov_d = 1'b0;
                end
            end
            S_LOAD: begin
                muxsel = 1'b1;
                ldw    = 1'b1;
                ldd    = 1'b1;
                clrcnt = 1'b1;
                busy   = 1'b1;
                // Divide-by-zero outranks overflow, so at most one flag is set.
                if (divbyzero) begin
                    state_d  = S_ERR;
                    err_dz_d = 1'b1;
                end else if (ov) begin
                    state_d  = S_ERR;
                    err_ov_d = 1'b1;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shw     = 1'b1;
                busy    = 1'b1;
                state_d = S_SUB;
            end
            S_SUB: begin
                add_sub_sel = 1'b1;
                cnt_en      = 1'b1;
                busy        = 1'b1;
                // A non-negative difference commits the remainder and sets q0.
                // A negative one restores by leaving W untouched.
                if (!is_neg) begin
                    muxsel    = 1'b0;
                    ldw       = 1'b1;
                    setq0_to1 = 1'b1;
                end
                state_d = co ? S_DONE : S_SHIFT;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reset overrides the state decode. The datapath is cleared and every
        // other strobe is held low, including the registered error flags.
        if (rst) begin
            state_d     = S_IDLE;
            err_dz_d    = 1'b0;
            err_ov_d    = 1'b0;
            muxsel      = 1'b0;
            ldw         = 1'b0;
            shw         = 1'b0;
            setq0_to1   = 1'b0;
            add_sub_sel = 1'b0;
            ldd         = 1'b0;
            cnt_en      = 1'b0;
            busy        = 1'b0;
            done        = 1'b0;
            err_dz      = 1'b0;
            err_ov      = 1'b0;
            clrw        = 1'b1;
            clrd        = 1'b1;
            clrcnt      = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_ctrl
// Description : Self-checking bench for div_ctrl with a behavioural divider
//               datapath. Directed divisions push expected results into a
//               scoreboard queue. A monitor pops and compares on every done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

    logic clk = 1'b0;
    logic rst, start, ov, divbyzero, is_neg, co;
    logic muxsel, ldw, shw, clrw, ser_in, setq0_to1, add_sub_sel;
    logic ldd, clrd, clrcnt, cnt_en, busy, done, err_dz, err_ov;

    always #5 clk = ~clk;

    div_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .ov(ov), .divbyzero(divbyzero),
        .is_neg(is_neg), .co(co), .muxsel(muxsel), .ldw(ldw), .shw(shw),
        .clrw(clrw), .ser_in(ser_in), .setq0_to1(setq0_to1),
        .add_sub_sel(add_sub_sel), .ldd(ldd), .clrd(clrd), .clrcnt(clrcnt),
        .cnt_en(cnt_en), .busy(busy), .done(done), .err_dz(err_dz),
        .err_ov(err_ov)
    );

    // ---------------- behavioural datapath ----------------
    logic [9:0]  dividend;
    logic [4:0]  divisor;
    logic [10:0] w_q;
    logic [4:0]  d_q;
    logic [2:0]  cnt_q;
    logic [6:0]  as_res;

    assign as_res    = add_sub_sel ? ({1'b0, w_q[10:5]} - {2'b00, d_q})
                                   : ({1'b0, w_q[10:5]} + {2'b00, d_q});
    assign is_neg    = as_res[6];
    assign co        = (cnt_q == 3'd4);
    assign ov        = (dividend[9:5] >= divisor);
    assign divbyzero = (divisor == 5'd0);

    always @(posedge clk) begin
        if (clrw)      w_q <= '0;
        else if (ldw)  w_q <= muxsel ? {1'b0, dividend}
                                     : {as_res[5:0], w_q[4:1], w_q[0] | setq0_to1};
        else if (shw)  w_q <= {w_q[9:0], ser_in};
        if (clrd)      d_q <= '0;
        else if (ldd)  d_q <= divisor;
        if (clrcnt)    cnt_q <= '0;
        else if (cnt_en) cnt_q <= cnt_q + 3'd1;
    end

    // ---------------- scoreboard / checking ----------------
    typedef struct {
        int          cyc;
        logic [10:0] w;
        logic        dz;
        logic        ovf;
        bit          chk_w;
        int          shifts;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_count = 0;
    int   shift_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [14:0] outs();
        return {muxsel, ldw, shw, clrw, ser_in, setq0_to1, add_sub_sel,
                ldd, clrd, clrcnt, cnt_en, busy, done, err_dz, err_ov};
    endfunction

    localparam logic [14:0] RST_OUTS = 15'b000100001100000;

    // Monitor: samples just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (muxsel && ldw) shift_count = 0;
        if (shw) shift_count++;
        if (done) begin
            exp_t e;
            done_count++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("err_dz", {31'd0, err_dz}, {31'd0, e.dz});
                check("err_ov", {31'd0, err_ov}, {31'd0, e.ovf});
                check("busy_at_done", {31'd0, busy}, 32'd0);
                check("shift_cycles", shift_count, e.shifts);
                if (e.chk_w) check("w_result", {21'd0, w_q}, {21'd0, e.w});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input int dvd, input int dvs, input int lat, input int w,
                         input bit dz, input bit ovf, input bit push);
        exp_t e;
        @(negedge clk);
        dividend = dvd[9:0];
        divisor  = dvs[4:0];
        start    = 1'b1;
        if (push) begin
            e.cyc = cyc + lat; e.w = w[10:0]; e.dz = dz; e.ovf = ovf;
            e.chk_w = !(dz || ovf); e.shifts = (dz || ovf) ? 0 : 5;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            check("done_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int dc;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        #1 check("reset_outputs", {17'd0, outs()}, {17'd0, RST_OUTS});
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", {17'd0, outs()}, 32'd0);

        // 100 / 7 -> q 14, r 2
        issue(100, 7, 12, 78, 0, 0, 1);
        drain();
        // 991 / 31 -> q 31, r 30 (largest non-overflowing case)
        issue(991, 31, 12, 991, 0, 0, 1);
        drain();
        // divide by zero
        issue(500, 0, 2, 0, 1, 0, 1);
        drain();
        // overflow; flag must persist in IDLE, then clear on next start
        issue(1000, 3, 2, 0, 0, 1, 1);
        drain();
        check("err_ov_held", {31'd0, err_ov}, 32'd1);
        check("err_dz_held", {31'd0, err_dz}, 32'd0);
        issue(100, 7, 12, 78, 0, 0, 1);
        @(negedge clk);
        check("err_ov_cleared", {31'd0, err_ov}, 32'd0);
        drain();

        // reset in cycle 6 aborts the division with no done pulse
        dc = done_count;
        issue(100, 7, 12, 78, 0, 0, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1 check("abort_rst_outputs", {17'd0, outs()}, {17'd0, RST_OUTS});
        @(negedge clk) rst = 1'b0;
        #1 check("abort_idle_outputs", {17'd0, outs()}, 32'd0);
        repeat (15) @(negedge clk);
        check("abort_no_done", done_count - dc, 32'd0);
        issue(100, 7, 12, 78, 0, 0, 1);
        drain();

        // start pulses in cycles 3 and 8 while busy are ignored
        dc = done_count;
        issue(100, 7, 12, 78, 0, 0, 1);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        drain();
        repeat (5) @(negedge clk);
        check("single_done", done_count - dc, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
